// File: rtl/frame_pixel_writer_pkg.sv
// Constants and pixel record shared by the drawer, this writer and scan-out.
package frame_pixel_writer_pkg;

  localparam int H_PIXELS     = 160;
  localparam int V_PIXELS     = 120;
  localparam int COLOUR_BITS  = 3;
  localparam int FB_ADDR_BITS = 15;
  localparam int FIFO_DEPTH   = 4;

  localparam logic [FB_ADDR_BITS-1:0] LAST_PIXEL_ADDR = 15'd19199;

  typedef struct packed {
    logic [FB_ADDR_BITS-1:0] addr;
    logic [COLOUR_BITS-1:0]  colour;
  } pixel_t;

  // y*160 + x built from shifts so no multiplier is needed.
  function automatic logic [FB_ADDR_BITS-1:0] pixel_addr(input logic [7:0] x,
                                                         input logic [6:0] y);
    logic [FB_ADDR_BITS-1:0] y_w;
    logic [FB_ADDR_BITS-1:0] x_w;
    y_w = {8'd0, y};
    x_w = {7'd0, x};
    return (y_w << 7) + (y_w << 5) + x_w;
  endfunction

endpackage

// File: rtl/frame_pixel_writer_pixel_fifo.sv
// Show-ahead synchronous FIFO: head word is visible combinationally while not empty.
module pixel_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/frame_pixel_writer.sv
// Buffers drawer pixels and writes them into the framebuffer when the write port is granted.
module frame_pixel_writer
  import frame_pixel_writer_pkg::*;
(
  input  logic        iClock,
  input  logic        iReset,
  input  logic [7:0]  iX,
  input  logic [6:0]  iY,
  input  logic [2:0]  iColour,
  input  logic        iPlot,
  output logic        oReady,
  input  logic        iMemGrant,
  output logic [14:0] oWrAddr,
  output logic [2:0]  oWrData,
  output logic        oWrEn,
  output logic        oFrameDone,
  output logic [14:0] oPixelCount,
  output logic [7:0]  oDropCount,
  output logic        oOverflow
);

  localparam logic [7:0] H_LIMIT = 8'(H_PIXELS);
  localparam logic [6:0] V_LIMIT = 7'(V_PIXELS);

  pixel_t      in_pixel;
  pixel_t      head_pixel;
  logic        fifo_full;
  logic        fifo_empty;
  logic        in_range;
  logic        accept;
  logic        push;
  logic        pop;
  logic        head_is_last;

  logic [14:0] pix_count_q, pix_count_d;
  logic [7:0]  drop_count_q, drop_count_d;
  logic        frame_done_q, frame_done_d;
  logic        overflow_q, overflow_d;

  assign in_range        = (iX < H_LIMIT) && (iY < V_LIMIT);
  assign accept          = iPlot && !fifo_full;
  assign push            = accept && in_range;
  assign pop             = !fifo_empty && iMemGrant;
  assign in_pixel.addr   = pixel_addr(iX, iY);
  assign in_pixel.colour = iColour;
  assign head_is_last    = (head_pixel.addr == LAST_PIXEL_ADDR);

  pixel_fifo #(
    .WIDTH($bits(pixel_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (iClock),
    .rst_i   (iReset),
    .push_i  (push),
    .wdata_i (in_pixel),
    .pop_i   (pop),
    .rdata_o (head_pixel),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    pix_count_d  = pix_count_q;
    drop_count_d = drop_count_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    if (pop) begin
      if (head_is_last) begin
        pix_count_d  = '0;
        frame_done_d = 1'b1;
      end else begin
        pix_count_d = pix_count_q + 1'b1;
      end
    end
    if (accept && !in_range && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 1'b1;
    if (iPlot && fifo_full) overflow_d = 1'b1;
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      pix_count_q  <= '0;
      drop_count_q <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      pix_count_q  <= pix_count_d;
      drop_count_q <= drop_count_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Stale RAM contents are masked so the write bus idles at zero when nothing is queued.
  assign oWrAddr     = fifo_empty ? '0 : head_pixel.addr;
  assign oWrData     = fifo_empty ? '0 : head_pixel.colour;
  assign oWrEn       = pop;
  assign oReady      = !fifo_full;
  assign oFrameDone  = frame_done_q;
  assign oPixelCount = pix_count_q;
  assign oDropCount  = drop_count_q;
  assign oOverflow   = overflow_q;

endmodule

// File: tb/tb_frame_pixel_writer.sv
// Random and directed pixel streams checked against a queue-based reference model.
module tb_frame_pixel_writer;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic [7:0]  iX = '0;
  logic [6:0]  iY = '0;
  logic [2:0]  iColour = '0;
  logic        iPlot = 1'b0;
  logic        oReady;
  logic        iMemGrant = 1'b0;
  logic [14:0] oWrAddr;
  logic [2:0]  oWrData;
  logic        oWrEn;
  logic        oFrameDone;
  logic [14:0] oPixelCount;
  logic [7:0]  oDropCount;
  logic        oOverflow;

  frame_pixel_writer dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iX          (iX),
    .iY          (iY),
    .iColour     (iColour),
    .iPlot       (iPlot),
    .oReady      (oReady),
    .iMemGrant   (iMemGrant),
    .oWrAddr     (oWrAddr),
    .oWrData     (oWrData),
    .oWrEn       (oWrEn),
    .oFrameDone  (oFrameDone),
    .oPixelCount (oPixelCount),
    .oDropCount  (oDropCount),
    .oOverflow   (oOverflow)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    int addr;
    int col;
  } exp_t;

  // Reference model: buffered addresses, scoreboard of expected writes, flags.
  int   fifo_m[$];
  exp_t sb[$];
  int   cnt_m  = 0;
  int   drop_m = 0;
  bit   ovf_m  = 0;
  bit   done_m = 0;
  bit   final_chk = 0;
  bit   final_done = 0;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge iClock) begin
    exp_t e;
    chk("ready", int'(oReady), int'(fifo_m.size() < 4));
    chk("wren", int'(oWrEn), int'(iMemGrant && fifo_m.size() > 0));
    if (oWrEn) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", int'(oWrAddr), e.addr);
        chk("wr_data", int'(oWrData), e.col);
      end
    end else if (fifo_m.size() == 0) begin
      chk("idle_addr", int'(oWrAddr), 0);
      chk("idle_data", int'(oWrData), 0);
    end
    chk("pixel_count", int'(oPixelCount), cnt_m);
    chk("frame_done", int'(oFrameDone), int'(done_m));
    chk("drop_count", int'(oDropCount), drop_m);
    chk("overflow", int'(oOverflow), int'(ovf_m));
    if (final_chk && !final_done) begin
      chk("scoreboard_left", sb.size(), 0);
      final_done = 1;
    end
  end

  task automatic clear_model();
    fifo_m.delete();
    sb.delete();
    cnt_m  = 0;
    drop_m = 0;
    ovf_m  = 0;
    done_m = 0;
  endtask

  // Drive one cycle of inputs, then advance the model by the rules of the block.
  task automatic step(input int x, input int y, input int c, input bit plot, input bit grant);
    bit ready_m;
    int head;
    iX        = 8'(x);
    iY        = 7'(y);
    iColour   = 3'(c);
    iPlot     = plot;
    iMemGrant = grant;
    @(posedge iClock);
    ready_m = fifo_m.size() < 4;
    done_m  = 0;
    if (grant && fifo_m.size() > 0) begin
      head = fifo_m.pop_front();
      if (head == 19199) begin
        cnt_m  = 0;
        done_m = 1;
      end else begin
        cnt_m = (cnt_m + 1) % 32768;
      end
    end
    if (plot) begin
      if (!ready_m) ovf_m = 1;
      else if (x < 160 && y < 120) begin
        fifo_m.push_back(y * 160 + x);
        sb.push_back('{addr: y * 160 + x, col: c});
      end else if (drop_m < 255) drop_m++;
    end
    #1;
  endtask

  task automatic idle(input int n, input bit grant);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, grant);
  endtask

  task automatic do_reset();
    iReset    = 1'b1;
    iPlot     = 1'b0;
    iMemGrant = 1'b1;
    clear_model();
    repeat (2) @(posedge iClock);
    #1;
    iReset = 1'b0;
  endtask

  initial begin
    int x;
    int y;
    do_reset();

    step(0, 0, 5, 1, 1);
    idle(2, 1);
    step(10, 2, 3, 1, 1);
    step(159, 119, 6, 1, 1);
    idle(3, 1);

    for (int i = 0; i < 5; i++) step(i, 1, i, 1, 0);
    idle(6, 1);

    step(160, 0, 1, 1, 1);
    step(0, 120, 2, 1, 1);
    idle(2, 1);
    for (int i = 0; i < 300; i++) step(160 + (i % 96), i % 128, 0, 1, 1);
    idle(2, 1);

    do_reset();
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++)
        step(xx, yy, int'($urandom_range(0, 7)), 1, 1);
    idle(3, 1);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        x = 159;
        y = 119;
      end else begin
        x = int'($urandom_range(0, 175));
        y = int'($urandom_range(0, 127));
      end
      step(x, y, int'($urandom_range(0, 7)), $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 6);
    end
    idle(6, 1);

    for (int i = 0; i < 3; i++) step(20 + i, 5, i + 1, 1, 0);
    do_reset();
    idle(3, 1);

    final_chk = 1;
    idle(2, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
